// File: rtl/xres_cond_pkg.sv
// rtl/xres_cond_pkg.sv - shared types, widths and channel-scan helper for the XRES conditioner
package xres_cond_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } xres_state_t;

  localparam int EVT_W  = 8;
  localparam int MAX_CH = 16;
  localparam int IDX_W  = $clog2(MAX_CH);
  // One extra code so "no channel left" (== MAX_CH) is representable.
  localparam int SCAN_W = $clog2(MAX_CH + 1);

  // Lowest set bit of mask at or above index from; MAX_CH when none remains.
  function automatic logic [SCAN_W-1:0] next_set(input logic [MAX_CH-1:0] mask,
                                                 input logic [SCAN_W-1:0] from);
    logic [SCAN_W-1:0] r;
    r = SCAN_W'(MAX_CH);
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (SCAN_W'(i) >= from)) r = SCAN_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/xres_glitch_filter.sv
// rtl/xres_glitch_filter.sv - pad reset synchroniser with bypassable mismatch-count glitch filter
module xres_glitch_filter #(
  parameter int FILT_CYC = 4
) (
  input  logic clock,
  input  logic resetb,
  input  logic xres_n,
  input  logic filt_en,
  output logic filt
);

  localparam int FC_W = $clog2(FILT_CYC + 1);

  logic            s1_q, s1_d;
  logic            xs_q, xs_d;
  logic            filt_q, filt_d;
  logic [FC_W-1:0] mcnt_q, mcnt_d;

  // Two-flop synchroniser and filter state registers; everything powers up in reset.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      s1_q   <= 1'b0;
      xs_q   <= 1'b0;
      filt_q <= 1'b0;
      mcnt_q <= '0;
    end else begin
      s1_q   <= s1_d;
      xs_q   <= xs_d;
      filt_q <= filt_d;
      mcnt_q <= mcnt_d;
    end
  end

  // Filtered level follows xs only after FILT_CYC consecutive disagreeing cycles.
  always_comb begin
    s1_d   = xres_n;
    xs_d   = s1_q;
    filt_d = filt_q;
    mcnt_d = '0;
    if (!filt_en) begin
      // Track xs while bypassed so re-enabling the filter starts from agreement.
      filt_d = xs_q;
    end else if (xs_q != filt_q) begin
      if (mcnt_q == FC_W'(FILT_CYC - 1)) filt_d = xs_q;
      else                               mcnt_d = mcnt_q + FC_W'(1);
    end
  end

  // Bypass presents the synchroniser output directly.
  always_comb begin
    filt = filt_en ? filt_q : xs_q;
  end

endmodule

// File: rtl/xres_conditioner.sv
// rtl/xres_conditioner.sv - stretches the filtered pad reset and releases channels in index order
module xres_conditioner
  import xres_cond_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int FILT_CYC    = 4,
  parameter int STRETCH_CYC = 16,
  parameter int RELEASE_GAP = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             xres_n,
  input  logic             filt_en,
  input  logic             soft_req,
  input  logic [NCH-1:0]   ch_mask,
  output logic [NCH-1:0]   rst_n,
  output logic             in_reset,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam int CMAX  = (STRETCH_CYC > RELEASE_GAP) ? STRETCH_CYC : RELEASE_GAP;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [SCAN_W-1:0] NONE = SCAN_W'(MAX_CH);

  xres_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCAN_W-1:0] idx_q, idx_d;
  logic [NCH-1:0]    mask_q, mask_d;
  logic [NCH-1:0]    rst_q, rst_d;
  logic [EVT_W-1:0]  evt_q, evt_d;

  logic              filt;
  logic              abort;
  logic              stretch_done, gap_done;
  logic [SCAN_W-1:0] first_ch, next_ch, sel_ch;
  logic [NCH-1:0]    sel_onehot;

  xres_glitch_filter #(.FILT_CYC(FILT_CYC)) u_filter (
    .clock   (clock),
    .resetb  (resetb),
    .xres_n  (xres_n),
    .filt_en (filt_en),
    .filt    (filt)
  );

  // Any loss of the filtered pad level or a software request restarts the whole sequence.
  assign abort        = (state_q != ST_ASSERT) && (!filt || soft_req);
  assign stretch_done = (cnt_q == CNT_W'(STRETCH_CYC - 1));
  assign gap_done     = (cnt_q == CNT_W'(RELEASE_GAP - 1));
  assign first_ch     = next_set(MAX_CH'(ch_mask), '0);
  assign next_ch      = next_set(MAX_CH'(mask_q), idx_q + SCAN_W'(1));

  // State register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state_q <= ST_ASSERT;
    else         state_q <= state_d;
  end

  // Next-state logic; masked channels are skipped without spending cycles.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_ASSERT;
    end else begin
      unique case (state_q)
        ST_ASSERT:  if (filt) state_d = ST_STRETCH;
        ST_STRETCH: if (stretch_done) state_d = (first_ch == NONE) ? ST_RUN : ST_RELEASE;
        ST_RELEASE: if (gap_done && (next_ch == NONE)) state_d = ST_RUN;
        ST_RUN:     state_d = ST_RUN;
        default:    state_d = ST_ASSERT;
      endcase
    end
  end

  // Datapath registers: shared stretch/gap counter, channel index, latched mask, resets, events.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      mask_q <= '0;
      rst_q  <= '0;
      evt_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      mask_q <= mask_d;
      rst_q  <= rst_d;
      evt_q  <= evt_d;
    end
  end

  // One-hot of the channel being released this cycle.
  always_comb begin
    sel_ch     = (state_q == ST_STRETCH) ? first_ch : next_ch;
    sel_onehot = '0;
    for (int i = 0; i < NCH; i++) sel_onehot[i] = (sel_ch == SCAN_W'(i));
  end

  // Datapath next values.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    mask_d = mask_q;
    rst_d  = rst_q;
    evt_d  = evt_q;
    if (abort) begin
      cnt_d = '0;
      idx_d = '0;
      rst_d = '0;
      evt_d = (evt_q == '1) ? evt_q : evt_q + EVT_W'(1);
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          cnt_d = '0;
          rst_d = '0;
        end
        ST_STRETCH: begin
          if (stretch_done) begin
            cnt_d  = '0;
            mask_d = ch_mask;
            idx_d  = first_ch;
            rst_d  = sel_onehot;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_done) begin
            cnt_d = '0;
            if (next_ch != NONE) begin
              idx_d = next_ch;
              rst_d = rst_q | sel_onehot;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    rst_n    = rst_q;
    in_reset = (state_q != ST_RUN);
    evt_cnt  = evt_q;
  end

endmodule

// File: tb/tb_xres_conditioner.sv
// tb/tb_xres_conditioner.sv - self-checking bench with timeline reference model for xres_conditioner
module tb_xres_conditioner;

  localparam int FILT = 4;
  localparam int STR  = 16;
  localparam int GAP  = 2;
  localparam int INF  = 32'h7fffffff;

  logic       clock = 1'b0;
  logic       resetb;
  logic       xres_n;
  logic       filt_en;
  logic       soft_req;
  logic [3:0] ch_mask;
  logic [3:0] rst_n;
  logic       in_reset;
  logic [7:0] evt_cnt;

  int checks = 0;
  int errors = 0;

  xres_conditioner dut (
    .clock    (clock),
    .resetb   (resetb),
    .xres_n   (xres_n),
    .filt_en  (filt_en),
    .soft_req (soft_req),
    .ch_mask  (ch_mask),
    .rst_n    (rst_n),
    .in_reset (in_reset),
    .evt_cnt  (evt_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge-counted timeline. On sequence start every channel gets
  // an absolute release time from its rank among the latched mask bits.
  int t_m = 0;
  bit sh1_m = 0, xs_m = 0, filt_m = 0;
  int run_m = 0;
  int phase_m = 0;
  int t0_m = 0;
  int rel_m[4];
  int runt_m = 0;
  int evt_m = 0;

  always @(posedge clock or negedge resetb) begin
    bit f;
    int r;
    if (!resetb) begin
      t_m = 0; sh1_m = 0; xs_m = 0; filt_m = 0; run_m = 0;
      phase_m = 0; t0_m = 0; runt_m = 0; evt_m = 0;
    end else begin
      t_m++;
      f = filt_en ? filt_m : xs_m;
      if (phase_m != 0 && (!f || soft_req)) begin
        phase_m = 0;
        if (evt_m < 255) evt_m++;
      end else if (phase_m == 0 && f) begin
        phase_m = 1;
        t0_m = t_m;
      end else if (phase_m == 1 && t_m == t0_m + STR) begin
        r = 0;
        for (int j = 0; j < 4; j++) begin
          if (ch_mask[j]) begin rel_m[j] = t_m + GAP * r; r++; end
          else rel_m[j] = INF;
        end
        runt_m = t_m + GAP * r;
        phase_m = 2;
      end
      if (!filt_en) begin
        filt_m = xs_m; run_m = 0;
      end else if (xs_m != filt_m) begin
        run_m++;
        if (run_m == FILT) begin filt_m = xs_m; run_m = 0; end
      end else begin
        run_m = 0;
      end
      xs_m = sh1_m;
      sh1_m = xres_n;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    logic [3:0] er;
    bit ei;
    er = '0;
    ei = 1'b1;
    if (phase_m == 2) begin
      for (int j = 0; j < 4; j++) er[j] = (rel_m[j] <= t_m);
      ei = (t_m < runt_m);
    end
    check("model_rst_n", int'(rst_n), int'(er));
    check("model_in_reset", int'(in_reset), int'(ei));
    check("model_evt_cnt", int'(evt_cnt), evt_m);
  end

  int rise[4];
  int fall_ir;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic record(input int n);
    for (int i = 0; i < 4; i++) rise[i] = -1;
    fall_ir = -1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) if (rst_n[i] && rise[i] < 0) rise[i] = c;
      if (!in_reset && fall_ir < 0) fall_ir = c;
    end
  endtask

  task automatic wait_rst(input logic [3:0] pat, input int max, input string nm);
    bit found;
    found = 0;
    for (int c = 0; c < max && !found; c++) begin
      @(negedge clock);
      if (rst_n == pat) found = 1;
    end
    check(nm, int'(found), 1);
  endtask

  task automatic wait_run(input int max, input string nm);
    bit found;
    found = 0;
    for (int c = 0; c < max && !found; c++) begin
      @(negedge clock);
      if (!in_reset) found = 1;
    end
    check(nm, int'(found), 1);
  endtask

  initial begin
    int pulse_left;
    resetb = 0; xres_n = 1; filt_en = 1; soft_req = 0; ch_mask = 4'hF;
    repeat (3) tick();
    #1;
    check("reset_rst_n", int'(rst_n), 0);
    check("reset_in_reset", int'(in_reset), 1);
    check("reset_evt_cnt", int'(evt_cnt), 0);

    // Power-on: edge 1 is the first edge after release.
    #1 resetb = 1;
    record(40);
    check("pwr_rise0", rise[0], 23);
    check("pwr_rise1", rise[1], 25);
    check("pwr_rise2", rise[2], 27);
    check("pwr_rise3", rise[3], 29);
    check("pwr_in_reset_fall", fall_ir, 31);
    check("pwr_evt_cnt", int'(evt_cnt), 0);

    // Glitch reject with filter, then the same pulse unfiltered.
    xres_n = 0; repeat (3) tick(); xres_n = 1;
    repeat (8) tick();
    check("glitch_filt_in_reset", int'(in_reset), 0);
    check("glitch_filt_rst_n", int'(rst_n), 15);
    check("glitch_filt_evt", int'(evt_cnt), 0);
    filt_en = 0;
    xres_n = 0; repeat (3) tick(); xres_n = 1;
    repeat (3) tick();
    check("glitch_nofilt_rst_n", int'(rst_n), 0);
    check("glitch_nofilt_evt", int'(evt_cnt), 1);
    filt_en = 1;
    wait_run(60, "glitch_rerun");

    // Mask 0101 latched at the release edge.
    ch_mask = 4'b0101; soft_req = 1; tick(); soft_req = 0;
    record(30);
    check("mask_rise0", rise[0], 17);
    check("mask_rise1", rise[1], -1);
    check("mask_rise2", rise[2], 19);
    check("mask_rise3", rise[3], -1);
    check("mask_run", fall_ir, 21);
    check("mask_evt", int'(evt_cnt), 2);
    ch_mask = 4'hF; repeat (5) tick();
    check("mask_hold", int'(rst_n), 5);

    // Soft request mid-sequence.
    soft_req = 1; tick(); soft_req = 0;
    wait_rst(4'b0011, 40, "mid_reach_0011");
    soft_req = 1; tick(); soft_req = 0;
    check("mid_rst_n", int'(rst_n), 0);
    check("mid_evt", int'(evt_cnt), 4);
    wait_run(60, "mid_rerun");
    check("mid_rerun_rst_n", int'(rst_n), 15);

    // Soft request in the same cycle the (unfiltered) pad level falls.
    filt_en = 0; xres_n = 0; tick(); tick();
    soft_req = 1; tick(); soft_req = 0;
    check("simul_evt", int'(evt_cnt), 5);
    check("simul_rst_n", int'(rst_n), 0);
    xres_n = 1; filt_en = 1;
    wait_run(80, "simul_rerun");

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      soft_req = 1; tick(); soft_req = 0; tick(); tick();
    end
    check("sat_evt", int'(evt_cnt), 255);

    // Asynchronous reset mid-release, checked before the next clock edge.
    wait_rst(4'b0001, 60, "async_reach_release");
    #1 resetb = 0;
    #1;
    check("async_rst_n", int'(rst_n), 0);
    check("async_in_reset", int'(in_reset), 1);
    check("async_evt", int'(evt_cnt), 0);
    repeat (3) tick();
    #1 resetb = 1;

    // Randomized traffic against the model.
    pulse_left = 0;
    for (int c = 0; c < 2500; c++) begin
      tick();
      soft_req = ($urandom_range(0, 59) == 0);
      if (pulse_left > 0) begin
        pulse_left--;
        if (pulse_left == 0) xres_n = 1;
      end else if ($urandom_range(0, 79) == 0) begin
        xres_n = 0;
        pulse_left = $urandom_range(1, 8);
      end
      if ($urandom_range(0, 49) == 0) ch_mask = 4'($urandom);
      if ($urandom_range(0, 199) == 0) filt_en = ~filt_en;
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
